// File: rtl/req_ack_pkg.sv
// Shared types and constants for the req/ack responder.
// Imported by the responder, its latency timer and its bound assertion module.
package req_ack_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, REL} resp_state_t;

  localparam int TIMER_W = 4;

endpackage

// File: rtl/latency_timer.sv
// Loadable down-counter that stops at zero and flags it.
// The responder uses it to hold WAIT for the ack latency.
module latency_timer
  import req_ack_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  // NOTE: every combinational output gets a default first so that no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/req_ack_responder_sva.sv
// Handshake properties for the responder, attached to every instance by bind.
// The WAIT cover stays unhit for LATENCY==1 instances.
module req_ack_responder_sva
  import req_ack_pkg::*;
(
  input logic        clk,
  input logic        rst,
  input logic        req,
  input logic        ack,
  input logic        abort_err,
  input resp_state_t state
);

  a_release: assert property (@(posedge clk) disable iff (rst) (ack && !req) |=> !ack);

  a_abort_no_ack: assert property (@(posedge clk) disable iff (rst) abort_err |-> !ack);

  a_abort_pulse: assert property (@(posedge clk) disable iff (rst) abort_err |=> !abort_err);

  a_ack_needs_req: assert property (@(posedge clk) disable iff (rst) $rose(ack) |-> $past(req));

  c_wait: cover property (@(posedge clk) disable iff (rst) state == WAIT);

endmodule

bind req_ack_responder req_ack_responder_sva u_sva (
  .clk      (clk),
  .rst      (rst),
  .req      (req),
  .ack      (ack),
  .abort_err(abort_err),
  .state    (state_q)
);

// File: rtl/req_ack_responder.sv
// Responder side of the four-phase req/ack handshake: samples req in IDLE,
// acks after LATENCY cycles with captured data + 1, and releases on req low.
module req_ack_responder
  import req_ack_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [DATA_W-1:0] req_data,
  output logic              ack,
  output logic [DATA_W-1:0] rsp_data,
  output logic              abort_err,
  output logic [CNT_W-1:0]  done_cnt
);

  localparam logic [TIMER_W-1:0] LOAD_VAL = TIMER_W'(LATENCY - 1);

  resp_state_t       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rsp_q, rsp_d;
  logic              ack_q, ack_d;
  logic              abort_q, abort_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timer_load;
  logic              timer_zero;

  latency_timer #(.W(TIMER_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .load_val(LOAD_VAL),
    .en      (state_q == WAIT),
    .zero    (timer_zero)
  );

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    rsp_d      = rsp_q;
    ack_d      = 1'b0;
    abort_d    = 1'b0;
    cnt_d      = cnt_q;
    timer_load = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          data_d = req_data;
          if (LATENCY == 1) begin
            state_d = ACK;
          end else begin
            state_d    = WAIT;
            timer_load = 1'b1;
          end
        end
      end

      WAIT: begin
        if (!req) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (timer_zero) begin
          state_d = ACK;
          ack_d   = 1'b1;
          rsp_d   = data_q + 1'b1;
        end
      end

      // With LATENCY==1 the first ACK cycle still has ack low; req dropping then is an abort.
      ACK: begin
        if (!req) begin
          if (ack_q) begin
            state_d = REL;
            cnt_d   = cnt_q + 1'b1;
          end else begin
            state_d = IDLE;
            abort_d = 1'b1;
          end
        end else begin
          ack_d = 1'b1;
          if (!ack_q) begin
            rsp_d = data_q + 1'b1;
          end
        end
      end

      REL:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      rsp_q   <= '0;
      ack_q   <= 1'b0;
      abort_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rsp_q   <= rsp_d;
      ack_q   <= ack_d;
      abort_q <= abort_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ack       = ack_q;
  assign rsp_data  = rsp_q;
  assign abort_err = abort_q;
  assign done_cnt  = cnt_q;

endmodule

// File: tb/tb_req_ack_responder.sv
// Directed bench for req_ack_responder with LATENCY 2, 3 and 1 instances.
module tb_req_ack_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       req2, req3, req1;
  logic [7:0] data2, data3, data1;
  logic       ack2, ack3, ack1;
  logic [7:0] rsp2, rsp3, rsp1;
  logic       abort2, abort3, abort1;
  logic [7:0] cnt2, cnt3, cnt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  req_ack_responder #(.DATA_W(8), .LATENCY(2), .CNT_W(8)) u_dut2 (
    .clk(clk), .rst(rst), .req(req2), .req_data(data2), .ack(ack2),
    .rsp_data(rsp2), .abort_err(abort2), .done_cnt(cnt2)
  );

  req_ack_responder #(.DATA_W(8), .LATENCY(3), .CNT_W(8)) u_dut3 (
    .clk(clk), .rst(rst), .req(req3), .req_data(data3), .ack(ack3),
    .rsp_data(rsp3), .abort_err(abort3), .done_cnt(cnt3)
  );

  req_ack_responder #(.DATA_W(8), .LATENCY(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .req_data(data1), .ack(ack1),
    .rsp_data(rsp1), .abort_err(abort1), .done_cnt(cnt1)
  );

  // One full LATENCY=2 handshake with a bounded wait for ack.
  task automatic hs2(input logic [7:0] d, output bit ok);
    req2  = 1'b1;
    data2 = d;
    ok    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack2) begin
        ok = 1'b1;
        break;
      end
    end
    req2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req2 = 1'b0; req3 = 1'b0; req1 = 1'b0;
    data2 = '0;  data3 = '0;  data1 = '0;
    repeat (2) @(negedge clk);
    checks++; if (ack2 !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ack2); end
    checks++; if (rsp2 !== 8'h00) begin errors++; $display("FAIL reset_rsp: got %h want 00", rsp2); end
    checks++; if (abort2 !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b want 0", abort2); end
    checks++; if (cnt2 !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt2); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    req2  = 1'b1;
    data2 = 8'h3C;
    @(negedge clk);
    checks++; if (ack2 !== 1'b0) begin errors++; $display("FAIL basic_ack_n0: got %b want 0", ack2); end
    @(negedge clk);
    checks++; if (ack2 !== 1'b0) begin errors++; $display("FAIL basic_ack_n1: got %b want 0", ack2); end
    @(negedge clk);
    checks++; if (ack2 !== 1'b1) begin errors++; $display("FAIL basic_ack_n2: got %b want 1", ack2); end
    checks++; if (rsp2 !== 8'h3D) begin errors++; $display("FAIL basic_rsp: got %h want 3d", rsp2); end
    req2 = 1'b0;
    @(negedge clk);
    checks++; if (ack2 !== 1'b0) begin errors++; $display("FAIL basic_release: got %b want 0", ack2); end
    checks++; if (cnt2 !== 8'd1) begin errors++; $display("FAIL basic_cnt: got %0d want 1", cnt2); end
    checks++; if (rsp2 !== 8'h3D) begin errors++; $display("FAIL basic_rsp_held: got %h want 3d", rsp2); end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    bit ok;
    bit all_ok = 1'b1;
    hs2(8'hFF, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_ff_ack: no ack within 8 cycles"); end
    checks++; if (rsp2 !== 8'h00) begin errors++; $display("FAIL wrap_rsp: got %h want 00", rsp2); end
    checks++; if (cnt2 !== 8'd2) begin errors++; $display("FAIL wrap_cnt2: got %0d want 2", cnt2); end
    for (int k = 0; k < 253; k++) begin
      hs2(8'(k), ok);
      if (!ok) all_ok = 1'b0;
    end
    checks++; if (!all_ok) begin errors++; $display("FAIL wrap_loop_ack: a handshake got no ack"); end
    checks++; if (cnt2 !== 8'd255) begin errors++; $display("FAIL wrap_cnt255: got %0d want 255", cnt2); end
    hs2(8'h41, ok);
    checks++; if (cnt2 !== 8'd0) begin errors++; $display("FAIL wrap_cnt0: got %0d want 0", cnt2); end
    checks++; if (rsp2 !== 8'h42) begin errors++; $display("FAIL wrap_rsp_last: got %h want 42", rsp2); end
  endtask

  task automatic test_abort();
    bit saw_ack = 1'b0;
    req3  = 1'b1;
    data3 = 8'h10;
    @(negedge clk);
    checks++; if (abort3 !== 1'b0) begin errors++; $display("FAIL abort_early: got %b want 0", abort3); end
    req3 = 1'b0;
    @(negedge clk);
    checks++; if (abort3 !== 1'b1) begin errors++; $display("FAIL abort_pulse: got %b want 1", abort3); end
    if (ack3) saw_ack = 1'b1;
    @(negedge clk);
    checks++; if (abort3 !== 1'b0) begin errors++; $display("FAIL abort_width: got %b want 0", abort3); end
    repeat (3) begin
      if (ack3) saw_ack = 1'b1;
      @(negedge clk);
    end
    checks++; if (saw_ack) begin errors++; $display("FAIL abort_no_ack: got ack=1 want 0"); end
    checks++; if (cnt3 !== 8'd0) begin errors++; $display("FAIL abort_cnt: got %0d want 0", cnt3); end
  endtask

  task automatic test_latency3();
    bit early = 1'b0;
    req3  = 1'b1;
    data3 = 8'h7E;
    repeat (3) begin
      @(negedge clk);
      if (ack3) early = 1'b1;
    end
    checks++; if (early) begin errors++; $display("FAIL lat3_early: ack=1 before edge N+3"); end
    @(negedge clk);
    checks++; if (ack3 !== 1'b1) begin errors++; $display("FAIL lat3_ack: got %b want 1", ack3); end
    checks++; if (rsp3 !== 8'h7F) begin errors++; $display("FAIL lat3_rsp: got %h want 7f", rsp3); end
    req3 = 1'b0;
    @(negedge clk);
    checks++; if (cnt3 !== 8'd1) begin errors++; $display("FAIL lat3_cnt: got %0d want 1", cnt3); end
    @(negedge clk);
  endtask

  task automatic test_latency1();
    req1  = 1'b1;
    data1 = 8'h00;
    @(negedge clk);
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL lat1_early: got %b want 0", ack1); end
    @(negedge clk);
    checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL lat1_ack: got %b want 1", ack1); end
    checks++; if (rsp1 !== 8'h01) begin errors++; $display("FAIL lat1_rsp: got %h want 01", rsp1); end
    req1 = 1'b0;
    @(negedge clk);
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL lat1_release: got %b want 0", ack1); end
    checks++; if (cnt1 !== 8'd1) begin errors++; $display("FAIL lat1_cnt: got %0d want 1", cnt1); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok = 1'b0;
    bit early = 1'b0;
    req2  = 1'b1;
    data2 = 8'h20;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack2) begin
        ok = 1'b1;
        break;
      end
    end
    checks++; if (!ok) begin errors++; $display("FAIL b2b_first_ack: no ack within 8 cycles"); end
    req2 = 1'b0;
    @(negedge clk);
    checks++; if (ack2 !== 1'b0) begin errors++; $display("FAIL b2b_release: got %b want 0", ack2); end
    req2  = 1'b1;
    data2 = 8'h30;
    repeat (3) begin
      @(negedge clk);
      if (ack2) early = 1'b1;
    end
    checks++; if (early) begin errors++; $display("FAIL b2b_early: ack=1 before edge M+4"); end
    @(negedge clk);
    checks++; if (ack2 !== 1'b1) begin errors++; $display("FAIL b2b_second_ack: got %b want 1", ack2); end
    checks++; if (rsp2 !== 8'h31) begin errors++; $display("FAIL b2b_rsp: got %h want 31", rsp2); end
    req2 = 1'b0;
    @(negedge clk);
    checks++; if (cnt2 !== 8'd2) begin errors++; $display("FAIL b2b_cnt: got %0d want 2", cnt2); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_ack();
    bit ok = 1'b0;
    req2  = 1'b1;
    data2 = 8'h55;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack2) begin
        ok = 1'b1;
        break;
      end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rmid_ack: no ack within 8 cycles"); end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if (ack2 !== 1'b0) begin errors++; $display("FAIL rmid_ack_drop: got %b want 0", ack2); end
    checks++; if (rsp2 !== 8'h00) begin errors++; $display("FAIL rmid_rsp: got %h want 00", rsp2); end
    checks++; if (cnt2 !== 8'd0) begin errors++; $display("FAIL rmid_cnt: got %0d want 0", cnt2); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ack2 !== 1'b0) begin errors++; $display("FAIL rmid_post_n0: got %b want 0", ack2); end
    @(negedge clk);
    checks++; if (ack2 !== 1'b0) begin errors++; $display("FAIL rmid_post_n1: got %b want 0", ack2); end
    @(negedge clk);
    checks++; if (ack2 !== 1'b1) begin errors++; $display("FAIL rmid_post_ack: got %b want 1", ack2); end
    checks++; if (rsp2 !== 8'h56) begin errors++; $display("FAIL rmid_post_rsp: got %h want 56", rsp2); end
    req2 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_abort();
    test_latency3();
    test_latency1();
    test_back_to_back();
    test_reset_mid_ack();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
